// File: rtl/uart_tx_9600.sv
// uart_tx_9600: UART transmitter paced by the 9600-baud divider toggle,
// which is sampled as data and edge-detected in the clk_in domain.
module uart_tx_9600 #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e state_q, state_d;
  logic s1_q, s2_q, p_q;
  logic tick;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stop_q, stop_d;
  logic par_q, par_d;
  logic tx_q, tx_d;
  logic done_q, done_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      s1_q <= baud_in;
      s2_q <= s1_q;
      p_q  <= s2_q;
    end
  end

  assign tick = s2_q & ~p_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a tick coinciding with acceptance is dropped on purpose
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LAST) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_out   = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_9600.sv
// tb_uart_tx_9600: four transmitter configurations (8N1, 8E1, 8O1, 8N2)
// checked against a frame model built from the line protocol.
module tb_uart_tx_9600;

  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic baud_in = 1'b0;
  logic [7:0] din [4];
  logic [3:0] vld = 4'h0;
  wire [3:0] txo, rdy, bsy, dn;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  localparam int PAR_C [4] = '{0, 1, 2, 0};
  localparam int STP_C [4] = '{1, 1, 1, 2};

  uart_tx_9600 #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_in(baud_in),
    .tx_data(din[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_9600 #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_in(baud_in),
    .tx_data(din[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_9600 #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_in(baud_in),
    .tx_data(din[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_9600 #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_in(baud_in),
    .tx_data(din[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .tx_out(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (4) @(posedge clk_in);
      #1 baud_in = ~baud_in;
    end
  end

  function automatic int nbits(input int i);
    return 9 + ((PAR_C[i] != 0) ? 1 : 0) + STP_C[i];
  endfunction

  // expected line levels, bit 0 = start bit
  function automatic logic [15:0] frame_model(input logic [7:0] d, input int i);
    logic [15:0] f;
    int ones;
    int pos;
    f = '0;
    ones = 0;
    for (int b = 0; b < 8; b++) begin
      f[1 + b] = d[b];
      ones += int'(d[b]);
    end
    pos = 9;
    if (PAR_C[i] == 1) begin
      f[pos] = 1'(ones % 2);
      pos++;
    end else if (PAR_C[i] == 2) begin
      f[pos] = 1'(1 - ones % 2);
      pos++;
    end
    for (int s = 0; s < STP_C[i]; s++) f[pos + s] = 1'b1;
    return f;
  endfunction

  function automatic int exp_sig(input int i);
    return (8 * nbits(i)) * 16 + 4 + 2 + 1;
  endfunction

  task automatic send(input int idx, input logic [7:0] d);
    int lim;
    @(negedge clk_in);
    din[idx] = d;
    vld[idx] = 1'b1;
    lim = 0;
    do begin
      @(negedge clk_in);
      lim++;
    end while (rdy[idx] !== 1'b0 && lim < 20);
    vld[idx] = 1'b0;
  endtask

  // samples one frame at negedges, starting with the cycle after the start edge
  task automatic capture(input int idx, input int inj_at, input logic [7:0] inj_d,
                         output logic [15:0] bits, output int fall_cyc, output int sig);
    int nb, lim, done_at, done_cnt;
    bit found, shape_ok, rdy_ok;
    nb = nbits(idx);
    bits = '0;
    fall_cyc = -1;
    done_at = -1;
    done_cnt = 0;
    shape_ok = 1'b1;
    rdy_ok = 1'b1;
    found = 1'b0;
    lim = 0;
    sig = -1;
    while (!found && lim < 64) begin
      @(negedge clk_in);
      if (txo[idx] === 1'b0) found = 1'b1;
      else lim++;
    end
    if (!found) return;
    fall_cyc = cyc;
    for (int k = 0; k <= nb * 8 + 1; k++) begin
      if (k > 0) @(negedge clk_in);
      if (k < nb * 8) begin
        if (k % 8 == 0) bits[k / 8] = txo[idx];
        else if (txo[idx] !== bits[k / 8]) shape_ok = 1'b0;
        if (rdy[idx] !== 1'b0 || bsy[idx] !== 1'b1) rdy_ok = 1'b0;
      end
      if (k == nb * 8 && (rdy[idx] !== 1'b1 || bsy[idx] !== 1'b0)) rdy_ok = 1'b0;
      if (dn[idx] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (inj_at >= 0 && k == inj_at) begin
        din[idx] = inj_d;
        vld[idx] = 1'b1;
      end
      if (inj_at >= 0 && k == nb * 8 - 4) vld[idx] = 1'b0;
    end
    sig = done_at * 16 + done_cnt * 4 + int'(shape_ok) * 2 + int'(rdy_ok);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    n_chk++;
    if (txo !== 4'hF) begin n_fail++; $display("FAIL reset_tx_out got=%h exp=f", txo); end
    n_chk++;
    if (rdy !== 4'hF) begin n_fail++; $display("FAIL reset_ready got=%h exp=f", rdy); end
    n_chk++;
    if (bsy !== 4'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", bsy); end
    n_chk++;
    if (dn !== 4'h0) begin n_fail++; $display("FAIL reset_done got=%h exp=0", dn); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic test_8n1();
    logic [15:0] bits;
    int fc, sig;
    send(0, 8'h55);
    capture(0, -1, 8'h00, bits, fc, sig);
    n_chk++;
    if (bits !== frame_model(8'h55, 0)) begin
      n_fail++; $display("FAIL t1_bits got=%h exp=%h", bits, frame_model(8'h55, 0));
    end
    n_chk++;
    if (sig !== exp_sig(0)) begin n_fail++; $display("FAIL t1_timing got=%0d exp=%0d", sig, exp_sig(0)); end
  endtask

  task automatic test_parity_stop();
    logic [15:0] bits;
    int fc, sig;
    for (int i = 1; i < 4; i++) begin
      send(i, 8'hA5);
      capture(i, -1, 8'h00, bits, fc, sig);
      n_chk++;
      if (bits !== frame_model(8'hA5, i)) begin
        n_fail++; $display("FAIL t2_bits cfg=%0d got=%h exp=%h", i, bits, frame_model(8'hA5, i));
      end
      n_chk++;
      if (sig !== exp_sig(i)) begin
        n_fail++; $display("FAIL t2_timing cfg=%0d got=%0d exp=%0d", i, sig, exp_sig(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b1, b2;
    int f1, f2, s1, s2, lim;
    @(negedge clk_in);
    din[0] = 8'h12;
    vld[0] = 1'b1;
    lim = 0;
    do begin
      @(negedge clk_in);
      lim++;
    end while (rdy[0] !== 1'b0 && lim < 20);
    din[0] = 8'h34;
    capture(0, -1, 8'h00, b1, f1, s1);
    vld[0] = 1'b0;
    capture(0, -1, 8'h00, b2, f2, s2);
    n_chk++;
    if (b1 !== frame_model(8'h12, 0)) begin n_fail++; $display("FAIL t3_bits1 got=%h exp=%h", b1, frame_model(8'h12, 0)); end
    n_chk++;
    if (b2 !== frame_model(8'h34, 0)) begin n_fail++; $display("FAIL t3_bits2 got=%h exp=%h", b2, frame_model(8'h34, 0)); end
    n_chk++;
    if (s1 !== exp_sig(0)) begin n_fail++; $display("FAIL t3_timing1 got=%0d exp=%0d", s1, exp_sig(0)); end
    n_chk++;
    if (s2 !== exp_sig(0)) begin n_fail++; $display("FAIL t3_timing2 got=%0d exp=%0d", s2, exp_sig(0)); end
    n_chk++;
    if (f2 - f1 !== 88) begin n_fail++; $display("FAIL t3_gap got=%0d exp=88", f2 - f1); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] bits;
    int fc, sig;
    send(0, 8'hF0);
    capture(0, 20, 8'h0F, bits, fc, sig);
    vld[0] = 1'b0;
    n_chk++;
    if (bits !== frame_model(8'hF0, 0)) begin n_fail++; $display("FAIL t4_bits got=%h exp=%h", bits, frame_model(8'hF0, 0)); end
    n_chk++;
    if (sig !== exp_sig(0)) begin n_fail++; $display("FAIL t4_timing got=%0d exp=%0d", sig, exp_sig(0)); end
    repeat (16) @(negedge clk_in);
    n_chk++;
    if ({rdy[0], txo[0]} !== 2'b11) begin n_fail++; $display("FAIL t4_idle_after got=%b exp=11", {rdy[0], txo[0]}); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] bits;
    int fc, sig, lim;
    send(0, 8'h00);
    lim = 0;
    while (txo[0] !== 1'b0 && lim < 64) begin
      @(negedge clk_in);
      lim++;
    end
    repeat (27) @(negedge clk_in);
    n_chk++;
    if (txo[0] !== 1'b0) begin n_fail++; $display("FAIL t5_mid_data got=%b exp=0", txo[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({txo[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
      n_fail++; $display("FAIL t5_async got=%b exp=1100", {txo[0], rdy[0], bsy[0], dn[0]});
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_in);
    send(0, 8'h3C);
    capture(0, -1, 8'h00, bits, fc, sig);
    n_chk++;
    if (bits !== frame_model(8'h3C, 0)) begin n_fail++; $display("FAIL t5_bits got=%h exp=%h", bits, frame_model(8'h3C, 0)); end
    n_chk++;
    if (sig !== exp_sig(0)) begin n_fail++; $display("FAIL t5_timing got=%0d exp=%0d", sig, exp_sig(0)); end
  endtask

  task automatic test_tick_align();
    logic [15:0] bits;
    int fc, sig, ca, lim;
    send(0, 8'h81);
    capture(0, -1, 8'h00, bits, fc, sig);
    ca = fc + 8 * ((cyc - fc) / 8 + 2);
    lim = 0;
    while (cyc != ca - 1 && lim < 200) begin
      @(negedge clk_in);
      lim++;
    end
    din[0] = 8'hC3;
    vld[0] = 1'b1;
    @(negedge clk_in);
    vld[0] = 1'b0;
    n_chk++;
    if (rdy[0] !== 1'b0 || cyc != ca) begin
      n_fail++; $display("FAIL t6_accept ready=%b cyc=%0d exp_cyc=%0d", rdy[0], cyc, ca);
    end
    capture(0, -1, 8'h00, bits, fc, sig);
    n_chk++;
    if (fc !== ca + 8) begin n_fail++; $display("FAIL t6_start_edge got=%0d exp=%0d", fc, ca + 8); end
    n_chk++;
    if (bits !== frame_model(8'hC3, 0)) begin n_fail++; $display("FAIL t6_bits got=%h exp=%h", bits, frame_model(8'hC3, 0)); end
    n_chk++;
    if (sig !== exp_sig(0)) begin n_fail++; $display("FAIL t6_timing got=%0d exp=%0d", sig, exp_sig(0)); end
  endtask

  task automatic test_random();
    logic [15:0] bits;
    logic [7:0] d;
    int fc, sig, idx;
    for (int n = 0; n < 8; n++) begin
      idx = int'($urandom_range(0, 3));
      d = 8'($urandom);
      send(idx, d);
      capture(idx, -1, 8'h00, bits, fc, sig);
      n_chk++;
      if (bits !== frame_model(d, idx)) begin
        n_fail++; $display("FAIL rnd_bits cfg=%0d data=%h got=%h exp=%h", idx, d, bits, frame_model(d, idx));
      end
      n_chk++;
      if (sig !== exp_sig(idx)) begin
        n_fail++; $display("FAIL rnd_timing cfg=%0d got=%0d exp=%0d", idx, sig, exp_sig(idx));
      end
      repeat (int'($urandom_range(1, 12))) @(negedge clk_in);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    test_reset();
    test_8n1();
    test_parity_stop();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_tick_align();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
